// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one shared full_adder cell, LSB first.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, res, nxt_res;
  logic [CW-1:0] cnt;
  logic cy, fa_s, fa_c;
  full_adder u_fa (.a(a[0]), .b(b[0]), .c(cy), .sum(fa_s), .carry(fa_c));
  // Sum bit enters at the MSB so the LSB-first stream lands in order after WIDTH shifts.
  assign nxt_res = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      res <= '0;
      cy <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sum_out <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a <= a_in;
          b <= b_in;
          cy <= cin;
          cnt <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          res <= nxt_res;
          a <= a >> 1;
          b <= b >> 1;
          cy <= fa_c;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            sum_out <= nxt_res;
            cout <= fa_c;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table vectors plus corner sequences, scoreboarded on done, for WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start8 = 1'b0, c8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start1 = 1'b0, c1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .cin(c8), .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8));
  serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
    .cin(c1), .busy(busy1), .done(done1), .sum_out(sum1), .cout(cout1));
  int checks = 0, failures = 0, dones8 = 0, dones1 = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;
  typedef struct {
    logic [7:0] a, b;
    logic c;
    logic [7:0] s;
    logic co;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("mutex8", {31'd0, busy8 & done8}, 0);
    chk("mutex1", {31'd0, busy1 & done1}, 0);
    if (done8) begin
      dones8++;
      if (q8.size() == 0) chk("unexpected_done8", {23'd0, cout8, sum8}, 32'hdead);
      else begin
        e8 = q8.pop_front();
        chk("result8", {23'd0, cout8, sum8}, {23'd0, e8});
      end
    end
    if (done1) begin
      dones1++;
      if (q1.size() == 0) chk("unexpected_done1", {30'd0, cout1, sum1}, 32'hdead);
      else begin
        e1 = q1.pop_front();
        chk("result1", {30'd0, cout1, sum1}, {30'd0, e1});
      end
    end
  end
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [8:0] exp);
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; start8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      chk("busy8_lat", {31'd0, busy8}, {31'd0, i < 8});
      chk("done8_lat", {31'd0, done8}, {31'd0, i == 8});
    end
    @(posedge clk);
    #1;
    chk("done8_fall", {31'd0, done8}, 0);
    chk("hold8", {23'd0, cout8, sum8}, {23'd0, exp});
  endtask
  initial begin
    int d0;
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vt[2] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'b1; start8 = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy8}, 0);
    chk("rst_done", {31'd0, done8}, 0);
    chk("rst_sum", {24'd0, sum8}, 0);
    chk("rst_cout", {31'd0, cout8}, 0);
    start8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) op8(vt[i].a, vt[i].b, vt[i].c, {vt[i].co, vt[i].s});
    // start pulsed mid-run must be dropped, not queued
    d0 = dones8;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("ignored_start_dones", dones8 - d0, 1);
    chk("ignored_sum", {24'd0, sum8}, 32'h30);
    // reset four edges into a run
    d0 = dones8;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy8}, 0);
    chk("midrst_done", {31'd0, done8}, 0);
    chk("midrst_sum", {24'd0, sum8}, 0);
    chk("midrst_cout", {31'd0, cout8}, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", dones8 - d0, 0);
    op8(8'h01, 8'h01, 1'b0, 9'h002);
    // start held high: one op per WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h003);
    q8.push_back(9'h100);
    @(posedge clk);
    #1 a8 = 8'h80; b8 = 8'h80;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      chk("b2b_done", {31'd0, done8}, {31'd0, i == 8 || i == 18});
      if (i == 18) start8 = 1'b0;
    end
    // WIDTH=1
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      a1 = 1'(v == 0); b1 = 1'b1; c1 = 1'(v == 0); start1 = 1'b1;
      q1.push_back(v == 0 ? 2'b11 : 2'b01);
      @(posedge clk);
      #1 start1 = 1'b0;
      chk("w1_busy", {31'd0, busy1}, 1);
      chk("w1_done_early", {31'd0, done1}, 0);
      @(posedge clk);
      #1;
      chk("w1_done", {31'd0, done1}, 1);
      chk("w1_busy_off", {31'd0, busy1}, 0);
      @(posedge clk);
      #1;
      chk("w1_done_fall", {31'd0, done1}, 0);
      chk("w1_hold", {30'd0, cout1, sum1}, v == 0 ? 3 : 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("w1_dones", dones1, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
